memwb_pipe_reg: RTL and testbench
=================================

Name: memwb_pipe_reg

Overview:
Parametrised MEM/WB pipeline register, the successor to the fixed 16-bit memwb stage. It carries the MEM-stage results to write-back over a valid/ready handshake with a one-entry skid buffer, so a write-back stall does not drop a beat. It also supports a pipeline flush, squashes register writes on arithmetic overflow, and keeps a saturating count of squashed beats.

Parameters:
DW, 16, width of the rd, alu_out, rd1 and rd15 data fields
OPW, 4, width of the op1 and op2 fields
RWW, 3, width of the reg_write field
CNTW, 8, width of the overflow squash counter

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
of  in  1  overflow flag for the beat presented this cycle
flush  in  1  discard all buffered and incoming beats
in_valid  in  1  MEM-stage beat present
in_ready  out  1  stage can accept a beat; equals !skid_valid
rd, alu_out, rd1, rd15  in  DW each  data payload
op1, op2  in  OPW each  opcode fields
reg_write  in  RWW  register write enables
f  in  1  flag bit
out_valid  out  1  WB-stage beat present
out_ready  in  1  WB stage consumes the beat
memwb_rd, memwb_alu_out, memwb_rd1, memwb_rd15  out  DW each  registered payload
memwb_op1, memwb_op2  out  OPW each  registered opcode fields
memwb_reg_write  out  RWW  registered write enables; zero when the beat was squashed
memwb_f  out  1  registered flag
memwb_exc  out  1  beat was squashed by overflow
of_count  out  CNTW  saturating count of squashed beats

Behaviour:
- Reset (clk and reset are the only clocking signals; reset is synchronous, active-high):
  - out_valid=0, skid_valid=0, so in_ready=1 on the first cycle after reset.
  - All memwb_* outputs = 0; of_count = 0.
  - Reset overrides flush and any handshake in the same cycle.
- Accept: a beat is accepted when in_valid && in_ready && !flush.
- Capture of an accepted beat:
  - Payload is captured as presented, except when of=1.
  - If of=1: reg_write is captured as 0, exc is captured as 1, and of_count increments (saturates at 2^CNTW-1).
  - If of=0: exc is captured as 0.
  - of is ignored on cycles with no accept.
- Output register update rule (out_free = !out_valid || out_ready):
  - skid_valid && out_free: the skid entry moves to the output; if a beat is also accepted, it fills the skid.
  - !skid_valid && out_free && accept: the beat goes to the output next cycle (1-cycle latency).
  - !out_free && accept: the beat goes to the skid, skid_valid=1, and in_ready drops next cycle.
  - out_free with nothing to load: out_valid=0.
- Payload holding:
  - Output payload holds its last value while out_valid=0; it is not zeroed except by reset.
  - The skid entry holds its contents until moved.
- Ordering: beats leave in acceptance order; no beat is duplicated or dropped except by flush.
- Flush:
  - Next cycle out_valid=0 and skid_valid=0.
  - The incoming beat in the flush cycle is not accepted, and of has no effect on of_count.
  - Payload registers are unchanged; of_count is not cleared.
- Simultaneous flush && out_ready: the current output beat counts as consumed by the WB stage; the buffer is still emptied.
- in_ready is combinational from skid_valid only (registered state); it has no path from in_valid or out_ready.
- Throughput: 1 beat/cycle when out_ready is held at 1.

Test Plan:
1. Reset held 2 cycles, then released -> out_valid=0, in_ready=1, of_count=0, every memwb_* output = 0.
2. Beat alu_out=A0A0, rd=0A0A, rd15=0098, op1=0001, op2=0010, reg_write=001, f=0, of=0, with out_ready=1 -> next cycle out_valid=1 and outputs match exactly, memwb_exc=0.
3. out_ready=0, then beats A0A0 and 1BEA sent back-to-back -> A0A0 held on the output, 1BEA in the skid, in_ready=0. Raise out_ready -> A0A0 consumed, then 1BEA (rd=0BEA, op2=1111, reg_write=100, f=1), in order.
4. Beat 1BEA with of=1, reg_write=100 -> memwb_reg_write=000, memwb_exc=1, of_count=1, other fields unchanged. Next beat with of=0 -> exc=0, count stays 1.
5. Skid full, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped beat never appears, of_count unchanged.
6. CNTW=2 build, 5 overflow beats -> of_count reads 1,2,3,3,3. Reset asserted mid-stream with in_valid=1 -> all state cleared on the next edge.

Source files
------------

// File: rtl/memwb_pipe_reg.sv
// MEM/WB pipeline register with a valid/ready handshake and a one-entry skid buffer.
// Overflowing beats have their register writes squashed and are tallied in a saturating counter.
module memwb_pipe_reg #(
  parameter int DW   = 16,
  parameter int OPW  = 4,
  parameter int RWW  = 3,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            of,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   rd,
  input  logic [DW-1:0]   alu_out,
  input  logic [DW-1:0]   rd1,
  input  logic [DW-1:0]   rd15,
  input  logic [OPW-1:0]  op1,
  input  logic [OPW-1:0]  op2,
  input  logic [RWW-1:0]  reg_write,
  input  logic            f,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   memwb_rd,
  output logic [DW-1:0]   memwb_alu_out,
  output logic [DW-1:0]   memwb_rd1,
  output logic [DW-1:0]   memwb_rd15,
  output logic [OPW-1:0]  memwb_op1,
  output logic [OPW-1:0]  memwb_op2,
  output logic [RWW-1:0]  memwb_reg_write,
  output logic            memwb_f,
  output logic            memwb_exc,
  output logic [CNTW-1:0] of_count
);

  // Beat layout: {rd, alu_out, rd1, rd15, op1, op2, reg_write, f, exc}
  localparam int PW = 4*DW + 2*OPW + RWW + 2;

  logic [PW-1:0]   in_beat;
  logic [PW-1:0]   out_reg;
  logic [PW-1:0]   skid_reg;
  logic            out_valid_reg;
  logic            skid_valid_reg;
  logic [CNTW-1:0] of_count_reg;
  logic [RWW-1:0]  reg_write_cap;
  logic            accept;
  logic            out_free;

  assign reg_write_cap = of ? {RWW{1'b0}} : reg_write;
  assign in_beat  = {rd, alu_out, rd1, rd15, op1, op2, reg_write_cap, f, of};
  assign in_ready = !skid_valid_reg;
  assign accept   = in_valid && in_ready && !flush;
  assign out_free = !out_valid_reg || out_ready;

  assign out_valid = out_valid_reg;
  assign of_count  = of_count_reg;
  assign {memwb_rd, memwb_alu_out, memwb_rd1, memwb_rd15, memwb_op1, memwb_op2,
          memwb_reg_write, memwb_f, memwb_exc} = out_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      out_reg        <= '0;
      skid_reg       <= '0;
      of_count_reg   <= '0;
    end else if (flush) begin
      // Flush empties the stage but leaves payloads and the squash count alone.
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      if (accept && of && of_count_reg != {CNTW{1'b1}})
        of_count_reg <= of_count_reg + CNTW'(1);
      if (out_free) begin
        if (skid_valid_reg) begin
          out_reg        <= skid_reg;
          out_valid_reg  <= 1'b1;
          skid_valid_reg <= accept;
          if (accept)
            skid_reg <= in_beat;
        end else if (accept) begin
          out_reg       <= in_beat;
          out_valid_reg <= 1'b1;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end else if (accept) begin
        // Output is stalled: park the beat so it is not lost.
        skid_reg       <= in_beat;
        skid_valid_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memwb_pipe_reg.sv
// Scoreboard bench for memwb_pipe_reg: a two-deep FIFO model predicts acceptance, ordering,
// flush and squash counting; a monitor pops and compares whenever the WB stage consumes a beat.
module tb_memwb_pipe_reg;

  typedef struct packed {
    logic [15:0] rd;
    logic [15:0] alu_out;
    logic [15:0] rd1;
    logic [15:0] rd15;
    logic [3:0]  op1;
    logic [3:0]  op2;
    logic [2:0]  reg_write;
    logic        f;
    logic        exc;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset, of, flush, in_valid, out_ready, f;
  logic        in_ready, out_valid;
  logic [15:0] rd, alu_out, rd1, rd15;
  logic [3:0]  op1, op2;
  logic [2:0]  reg_write;
  logic [15:0] memwb_rd, memwb_alu_out, memwb_rd1, memwb_rd15;
  logic [3:0]  memwb_op1, memwb_op2;
  logic [2:0]  memwb_reg_write;
  logic        memwb_f, memwb_exc;
  logic [7:0]  of_count;

  memwb_pipe_reg #(.DW(16), .OPW(4), .RWW(3), .CNTW(8)) dut (
    .clk(clk), .reset(reset), .of(of), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rd(rd), .alu_out(alu_out), .rd1(rd1), .rd15(rd15),
    .op1(op1), .op2(op2), .reg_write(reg_write), .f(f),
    .out_valid(out_valid), .out_ready(out_ready),
    .memwb_rd(memwb_rd), .memwb_alu_out(memwb_alu_out), .memwb_rd1(memwb_rd1),
    .memwb_rd15(memwb_rd15), .memwb_op1(memwb_op1), .memwb_op2(memwb_op2),
    .memwb_reg_write(memwb_reg_write), .memwb_f(memwb_f), .memwb_exc(memwb_exc),
    .of_count(of_count)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  int    beats_out = 0;
  beat_t exp_q[$];
  int    occ = 0;
  logic [7:0] exp_cnt = '0;
  beat_t last_shown = '0;
  bit    m_acc, m_cons;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
    end
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b.rd = rd; b.alu_out = alu_out; b.rd1 = rd1; b.rd15 = rd15;
    b.op1 = op1; b.op2 = op2; b.f = f;
    b.reg_write = of ? 3'b000 : reg_write;
    b.exc = of;
    return b;
  endfunction

  // Reference model: the stage is a FIFO of at most two beats in acceptance order.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      occ = 0;
      exp_cnt = '0;
    end else begin
      m_acc  = in_valid && (occ < 2) && !flush;
      m_cons = (occ > 0) && out_ready;
      if (m_acc && of && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      if (flush) begin
        exp_q.delete();
        occ = 0;
      end else begin
        occ = occ - int'(m_cons) + int'(m_acc);
        if (m_acc) exp_q.push_back(cur_beat());
      end
    end
  end

  // Monitor: samples mid-cycle, pops the front beat when it is consumed.
  initial forever begin
    beat_t act;
    @(negedge clk);
    act = {memwb_rd, memwb_alu_out, memwb_rd1, memwb_rd15, memwb_op1, memwb_op2,
           memwb_reg_write, memwb_f, memwb_exc};
    chk("in_ready", 128'(in_ready), 128'(occ < 2));
    chk("out_valid", 128'(out_valid), 128'(occ > 0));
    chk("of_count", 128'(of_count), 128'(exp_cnt));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("queue_nonempty", 128'(0), 128'(1));
      end else begin
        chk("payload", 128'(act), 128'(exp_q[0]));
        last_shown = exp_q[0];
        if (out_ready && !reset) begin
          beats_out++;
          $display("beat %0d: alu_out=%h rd=%h op2=%h reg_write=%b f=%b exc=%b",
                   beats_out, act.alu_out, act.rd, act.op2, act.reg_write, act.f, act.exc);
          void'(exp_q.pop_front());
        end
      end
    end else begin
      chk("payload_hold", 128'(act), 128'(last_shown));
    end
    if (reset) last_shown = '0;
  end

  task automatic set_payload(input logic [15:0] a_rd, a_alu, a_rd1, a_rd15,
                             input logic [3:0] a_op1, a_op2, input logic [2:0] a_rw,
                             input logic a_f);
    rd = a_rd; alu_out = a_alu; rd1 = a_rd1; rd15 = a_rd15;
    op1 = a_op1; op2 = a_op2; reg_write = a_rw; f = a_f;
  endtask

  task automatic drive(input logic iv, input logic ovf, input logic fl, input logic ordy);
    in_valid = iv; of = ovf; flush = fl; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic beat_a0a0();
    set_payload(16'h0A0A, 16'hA0A0, 16'h1111, 16'h0098, 4'b0001, 4'b0010, 3'b001, 1'b0);
  endtask

  task automatic beat_1bea();
    set_payload(16'h0BEA, 16'h1BEA, 16'h2222, 16'h0099, 4'b0001, 4'b1111, 3'b100, 1'b1);
  endtask

  initial begin
    reset = 1'b1; of = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_payload('0, '0, '0, '0, '0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(0, 0, 0, 1);

    // Single beat, 1-cycle latency
    beat_a0a0(); drive(1, 0, 0, 1);
    drive(0, 0, 0, 1);

    // Stall: output holds A0A0, 1BEA parks in the skid, then drain in order
    beat_a0a0(); drive(1, 0, 0, 0);
    beat_1bea(); drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);

    // Overflow squash, then a clean beat
    beat_1bea(); drive(1, 1, 0, 1);
    beat_1bea(); drive(1, 0, 0, 1);
    drive(0, 0, 0, 1);

    // Skid full, then flush with an overflowing incoming beat
    beat_a0a0(); drive(1, 0, 0, 0);
    beat_1bea(); drive(1, 0, 0, 0);
    set_payload(16'hDEAD, 16'hBEEF, 16'h0, 16'h0, 4'hF, 4'hF, 3'b111, 1'b1);
    drive(1, 1, 1, 0);
    drive(0, 0, 0, 1);
    beat_a0a0(); drive(1, 0, 1, 1);
    drive(0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      set_payload(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom));
      drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 2),
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 6));
    end

    // Drive the squash counter into saturation
    for (int i = 0; i < 300; i++) begin
      set_payload(16'($urandom), 16'(i), 16'h0, 16'h0, 4'h1, 4'h2, 3'b111, 1'b0);
      drive(1, 1, 0, 1);
    end
    drive(0, 0, 0, 1);
    chk("of_count_saturated", 128'(of_count), 128'(8'hFF));

    // Reset mid-stream with a beat presented
    beat_a0a0(); drive(1, 0, 0, 0);
    beat_1bea(); drive(1, 0, 0, 0);
    reset = 1'b1;
    drive(1, 1, 0, 0);
    reset = 1'b0;
    chk("reset_of_count", 128'(of_count), 128'(0));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
